store_demux: RTL and testbench

- Routes CPU store requests from the MEM stage to one of two write targets: data memory (port 0) or the memory-mapped I/O region (port 1).
- Routing is decided by address compare.
- Provides a one-deep registered output stage with valid/ready handshake on each side, so a slow target back-pressures the pipeline through req_ready.
- Also flags misaligned stores and counts completed writes per target.

---
 rtl/store_demux.sv | 154 +++++++++++++++
 tb/tb_store_demux.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_demux.sv
// Store demultiplexer: routes MEM-stage stores to data memory (port 0) or MMIO (port 1)
// through a one-deep registered stage, dropping misaligned stores and counting completions.
module store_demux #(
    parameter logic [31:0] MMIO_BASE = 32'hFFFF0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_data,
    input  logic [3:0]       req_be,
    output logic             m0_valid,
    input  logic             m0_ready,
    output logic [31:0]      m0_addr,
    output logic [31:0]      m0_data,
    output logic [3:0]       m0_be,
    output logic             m1_valid,
    input  logic             m1_ready,
    output logic [31:0]      m1_addr,
    output logic [31:0]      m1_data,
    output logic [3:0]       m1_be,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND0 = 2'd1,
        PEND1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                 w_accept;
    logic                 w_sel;
    logic                 w_good;
    logic [1:0]           w_valid;
    logic [1:0]           w_ready;
    logic [1:0]           w_done;
    logic [1:0]           w_load;
    logic [1:0][31:0]     w_addr_out;
    logic [1:0][31:0]     w_data_out;
    logic [1:0][3:0]      w_be_out;
    logic [1:0][CNT_W-1:0] w_cnt_out;
    logic                 r_err_pulse;
    logic [CNT_W-1:0]     r_err_cnt;

    assign w_sel      = (req_addr >= MMIO_BASE);
    assign w_valid[0] = (r_state == PEND0);
    assign w_valid[1] = (r_state == PEND1);
    assign w_ready[0] = m0_ready;
    assign w_ready[1] = m1_ready;
    assign w_done     = w_valid & w_ready;
    assign req_ready  = (r_state == IDLE) | (|w_done);
    assign w_accept   = req_valid & req_ready;

    // Legal byte-enable patterns must also sit on their natural alignment.
    always_comb begin
        w_good = 1'b0;
        case (req_be)
            4'b1111:                         w_good = (req_addr[1:0] == 2'b00);
            4'b0011, 4'b1100:                w_good = ~req_addr[0];
            4'b0001, 4'b0010,
            4'b0100, 4'b1000:                w_good = 1'b1;
            default:                         w_good = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept && w_good) begin
            w_state_next = w_sel ? PEND1 : PEND0;
        end else if (|w_done) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [31:0]      r_addr;
            logic [31:0]      r_data;
            logic [3:0]       r_be;
            logic [CNT_W-1:0] r_cnt;

            assign w_load[gi] = w_accept & w_good & (w_sel == 1'(gi));

            // Payload only reloads for its own port; the idle port keeps its last value.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_addr <= '0;
                    r_data <= '0;
                    r_be   <= '0;
                end else if (w_load[gi]) begin
                    r_addr <= req_addr;
                    r_data <= req_data;
                    r_be   <= req_be;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_done[gi] && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_addr_out[gi] = r_addr;
            assign w_data_out[gi] = r_data;
            assign w_be_out[gi]   = r_be;
            assign w_cnt_out[gi]  = r_cnt;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_err_pulse <= w_accept & ~w_good;
            if (w_accept && !w_good && (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign m0_valid  = w_valid[0];
    assign m0_addr   = w_addr_out[0];
    assign m0_data   = w_data_out[0];
    assign m0_be     = w_be_out[0];
    assign m1_valid  = w_valid[1];
    assign m1_addr   = w_addr_out[1];
    assign m1_data   = w_data_out[1];
    assign m1_be     = w_be_out[1];
    assign cnt0      = w_cnt_out[0];
    assign cnt1      = w_cnt_out[1];
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_store_demux.sv
// Directed bench for store_demux: routing, back-pressure, misaligned drops,
// asynchronous reset and counter saturation (second instance with 2-bit counters).
module tb_store_demux;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_be;
    logic        m0_ready;
    logic        m1_ready;

    logic        req_ready, m0_valid, m1_valid, err_pulse;
    logic [31:0] m0_addr, m0_data, m1_addr, m1_data;
    logic [3:0]  m0_be, m1_be;
    logic [15:0] err_cnt, cnt0, cnt1;

    logic        s_req_ready, s_m0_valid, s_m1_valid, s_err_pulse;
    logic [31:0] s_m0_addr, s_m0_data, s_m1_addr, s_m1_data;
    logic [3:0]  s_m0_be, s_m1_be;
    logic [1:0]  s_err_cnt, s_cnt0, s_cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    store_demux dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_data(m0_data), .m0_be(m0_be),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_data(m1_data), .m1_be(m1_be),
        .err_pulse(err_pulse), .err_cnt(err_cnt), .cnt0(cnt0), .cnt1(cnt1)
    );

    store_demux #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(s_req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
        .m0_valid(s_m0_valid), .m0_ready(m0_ready), .m0_addr(s_m0_addr),
        .m0_data(s_m0_data), .m0_be(s_m0_be),
        .m1_valid(s_m1_valid), .m1_ready(m1_ready), .m1_addr(s_m1_addr),
        .m1_data(s_m1_data), .m1_be(s_m1_be),
        .err_pulse(s_err_pulse), .err_cnt(s_err_cnt), .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_be    = b;
        $display("[%0t] store addr=0x%08h data=0x%08h be=%b", $time, a, d, b);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_be    = '0;
        m0_ready  = 1'b1;
        m1_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset state
        check_eq("rst_m0_valid", 32'(m0_valid), 32'd0);
        check_eq("rst_m1_valid", 32'(m1_valid), 32'd0);
        check_eq("rst_m0_addr", m0_addr, 32'h0);
        check_eq("rst_cnt0", 32'(cnt0), 32'd0);
        check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        step();

        // Simple dmem store with latency 1
        drive_store(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        check_eq("t1_req_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        check_eq("t1_m0_valid", 32'(m0_valid), 32'd1);
        check_eq("t1_m0_addr", m0_addr, 32'h0000_0010);
        check_eq("t1_m0_data", m0_data, 32'hDEAD_BEEF);
        check_eq("t1_m0_be", 32'(m0_be), 32'hF);
        check_eq("t1_m1_valid", 32'(m1_valid), 32'd0);
        check_eq("t1_err_pulse", 32'(err_pulse), 32'd0);
        check_eq("t1_cnt0_early", 32'(cnt0), 32'd0);
        step();
        check_eq("t1_cnt0", 32'(cnt0), 32'd1);
        check_eq("t1_m0_valid_off", 32'(m0_valid), 32'd0);
        check_eq("t1_m1_valid_off", 32'(m1_valid), 32'd0);

        // MMIO store stalled three cycles
        m1_ready = 1'b0;
        drive_store(32'hFFFF_0004, 32'h0000_0055, 4'h1);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("t2_m1_valid_%0d", i), 32'(m1_valid), 32'd1);
            check_eq($sformatf("t2_m1_addr_%0d", i), m1_addr, 32'hFFFF_0004);
            check_eq($sformatf("t2_m1_data_%0d", i), m1_data, 32'h0000_0055);
            check_eq($sformatf("t2_m1_be_%0d", i), 32'(m1_be), 32'h1);
            check_eq($sformatf("t2_m0_valid_%0d", i), 32'(m0_valid), 32'd0);
            check_eq($sformatf("t2_req_ready_%0d", i), 32'(req_ready), 32'd0);
            step();
        end
        check_eq("t2_cnt1_stall", 32'(cnt1), 32'd0);
        m1_ready = 1'b1;
        #1;
        check_eq("t2_req_ready_rel", 32'(req_ready), 32'd1);
        step();
        check_eq("t2_cnt1", 32'(cnt1), 32'd1);
        check_eq("t2_m1_valid_off", 32'(m1_valid), 32'd0);

        // Back-to-back alternating stores, no bubbles
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = (i % 2 == 0) ? 32'h0000_0100 : 32'hFFFF_0000;
            drive_store(a, 32'hA000_0000 + 32'(i), 4'hF);
            check_eq($sformatf("t3_req_ready_%0d", i), 32'(req_ready), 32'd1);
            step();
            if (i % 2 == 0) begin
                check_eq($sformatf("t3_m0_valid_%0d", i), 32'(m0_valid), 32'd1);
                check_eq($sformatf("t3_m1_valid_%0d", i), 32'(m1_valid), 32'd0);
                check_eq($sformatf("t3_m0_data_%0d", i), m0_data, 32'hA000_0000 + 32'(i));
            end else begin
                check_eq($sformatf("t3_m1_valid_%0d", i), 32'(m1_valid), 32'd1);
                check_eq($sformatf("t3_m0_valid_%0d", i), 32'(m0_valid), 32'd0);
                check_eq($sformatf("t3_m1_data_%0d", i), m1_data, 32'hA000_0000 + 32'(i));
            end
        end
        req_valid = 1'b0;
        step();
        check_eq("t3_cnt0", 32'(cnt0), 32'd3);
        check_eq("t3_cnt1", 32'(cnt1), 32'd3);
        check_eq("t3_m1_addr_hold", m1_addr, 32'hFFFF_0000);

        // Misaligned stores are dropped and counted
        drive_store(32'h0000_0002, 32'h1111_1111, 4'hF);
        step();
        req_valid = 1'b0;
        check_eq("t4_m0_valid", 32'(m0_valid), 32'd0);
        check_eq("t4_m1_valid", 32'(m1_valid), 32'd0);
        check_eq("t4_err_pulse", 32'(err_pulse), 32'd1);
        check_eq("t4_err_cnt", 32'(err_cnt), 32'd1);
        step();
        check_eq("t4_err_pulse_off", 32'(err_pulse), 32'd0);
        drive_store(32'h0000_0000, 32'h2222_2222, 4'h0);
        step();
        req_valid = 1'b0;
        check_eq("t4_be0_err_pulse", 32'(err_pulse), 32'd1);
        check_eq("t4_be0_err_cnt", 32'(err_cnt), 32'd2);
        drive_store(32'h0000_0001, 32'h3333_3333, 4'b0011);
        step();
        req_valid = 1'b0;
        check_eq("t4_half_err_cnt", 32'(err_cnt), 32'd3);
        check_eq("t4_half_m0_valid", 32'(m0_valid), 32'd0);
        drive_store(32'h0000_0006, 32'h4444_4444, 4'b1100);
        step();
        req_valid = 1'b0;
        check_eq("t4_upper_m0_valid", 32'(m0_valid), 32'd1);
        check_eq("t4_upper_m0_addr", m0_addr, 32'h0000_0006);
        check_eq("t4_upper_err_pulse", 32'(err_pulse), 32'd0);
        step();
        check_eq("t4_upper_cnt0", 32'(cnt0), 32'd4);

        // Asynchronous reset while port 0 is stalled
        m0_ready = 1'b0;
        drive_store(32'h0000_0020, 32'h5555_5555, 4'hF);
        step();
        req_valid = 1'b0;
        check_eq("t5_m0_valid_pre", 32'(m0_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_m0_valid_async", 32'(m0_valid), 32'd0);
        check_eq("t5_m0_addr", m0_addr, 32'h0);
        check_eq("t5_cnt0", 32'(cnt0), 32'd0);
        check_eq("t5_cnt1", 32'(cnt1), 32'd0);
        check_eq("t5_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("t5_req_ready_idle", 32'(req_ready), 32'd1);
        check_eq("t5_m0_valid_idle", 32'(m0_valid), 32'd0);

        // Counter saturation on the 2-bit instance
        m0_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_store(32'h0000_0040 + 32'(4 * i), 32'hC000_0000 + 32'(i), 4'hF);
            step();
        end
        req_valid = 1'b0;
        step();
        check_eq("t6_cnt0_wide", 32'(cnt0), 32'd5);
        check_eq("t6_cnt0_sat", 32'(s_cnt0), 32'd3);
        check_eq("t6_m0_valid_off", 32'(s_m0_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
